// File: rtl/phi2_mode_sequencer_if.sv
// Handshake bundle between the PHI2 mode sequencer and its host.
// The master drives enable/test_rise. The slave (the sequencer) returns the count and mode results.
interface phi2_mode_sequencer_if #(
  parameter int COUNT_W = 16
);
  logic               enable;
  logic               test_rise;
  logic [COUNT_W-1:0] edge_count;
  logic               count_valid;
  logic [1:0]         mode;
  logic               mode_locked;
  logic               mode_change;

  modport master (
    output enable,
    output test_rise,
    input  edge_count,
    input  count_valid,
    input  mode,
    input  mode_locked,
    input  mode_change
  );

  modport slave (
    input  enable,
    input  test_rise,
    output edge_count,
    output count_valid,
    output mode,
    output mode_locked,
    output mode_change
  );
endinterface

// File: rtl/phi2_mode_sequencer.sv
// Measures PHI2 strobe counts in fixed windows, classifies them and commits a debounced bus mode.
// Optional fast clock-loss detection is built when PHI2_LOSS_FAST_EN is defined.
//
// state   | meaning
// IDLE    | disabled, counters held at zero
// MEASURE | counting test_rise strobes for WINDOW_CYC cycles
// EVAL    | classify the finished window, update candidate/streak/mode
module phi2_mode_sequencer #(
  parameter int WINDOW_CYC = 50000,
  parameter int COUNT_W    = 16,
  parameter int C64_MIN    = 900,
  parameter int C64_MAX    = 1100,
  parameter int C128_MIN   = 1900,
  parameter int C128_MAX   = 2150,
  parameter int CONFIRM    = 4,
  parameter int LOSS_CYC   = 2000
) (
  input logic                  clk_ref,
  input logic                  rst,
  phi2_mode_sequencer_if.slave bus
);

  localparam int WIN_W = $clog2(WINDOW_CYC + 1);
  localparam int STK_W = $clog2(CONFIRM + 1);

  localparam logic [1:0] MODE_NONE    = 2'b00;
  localparam logic [1:0] MODE_C64     = 2'b01;
  localparam logic [1:0] MODE_C128    = 2'b10;
  localparam logic [1:0] MODE_UNKNOWN = 2'b11;

  if (WINDOW_CYC < 1) begin : g_bad_window
    $error("phi2_mode_sequencer: WINDOW_CYC must be >= 1");
  end
  if (CONFIRM < 1) begin : g_bad_confirm
    $error("phi2_mode_sequencer: CONFIRM must be >= 1");
  end
  if (LOSS_CYC < 1) begin : g_bad_loss
    $error("phi2_mode_sequencer: LOSS_CYC must be >= 1");
  end
  if (C64_MIN > C64_MAX || C128_MIN > C128_MAX) begin : g_bad_bands
    $error("phi2_mode_sequencer: classification band min exceeds max");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_EVAL    = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIN_W-1:0]   win_q;
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] edge_count_q;
  logic               count_valid_q;
  logic [1:0]         mode_q;
  logic               mode_locked_q;
  logic               mode_change_q;
  logic [1:0]         cand_q;
  logic [STK_W-1:0]   streak_q;

  logic [COUNT_W-1:0] cnt_d;
  logic [1:0]         class_d;
  logic [1:0]         cand_d;
  logic [STK_W-1:0]   streak_d;
  logic               commit_d;

`ifdef PHI2_LOSS_FAST_EN
  localparam int RUN_W = $clog2(LOSS_CYC + 1);
  logic [RUN_W-1:0] run_q;
  logic             loss_q;
  logic             loss_hit;

  // run_q counts down the strobe-free cycles still allowed before loss
  assign loss_hit = (state_q == ST_MEASURE) && !bus.test_rise && (run_q == RUN_W'(1));
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (bus.test_rise && (cnt_q != {COUNT_W{1'b1}})) begin
      cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  always_comb begin
    class_d = MODE_UNKNOWN;
    if (edge_count_q == '0) begin
      class_d = MODE_NONE;
    end else if (edge_count_q >= COUNT_W'(C64_MIN) && edge_count_q <= COUNT_W'(C64_MAX)) begin
      class_d = MODE_C64;
    end else if (edge_count_q >= COUNT_W'(C128_MIN) && edge_count_q <= COUNT_W'(C128_MAX)) begin
      class_d = MODE_C128;
    end
  end

  always_comb begin
    cand_d   = cand_q;
    streak_d = streak_q;
    if (class_d == cand_q) begin
      if (streak_q != STK_W'(CONFIRM)) begin
        streak_d = streak_q + STK_W'(1);
      end
    end else begin
      cand_d   = class_d;
      streak_d = STK_W'(1);
    end
    commit_d = (streak_d == STK_W'(CONFIRM)) && (cand_d != mode_q);
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      win_q         <= '0;
      cnt_q         <= '0;
      edge_count_q  <= '0;
      count_valid_q <= 1'b0;
      mode_q        <= MODE_NONE;
      mode_locked_q <= 1'b0;
      mode_change_q <= 1'b0;
      cand_q        <= MODE_NONE;
      streak_q      <= '0;
`ifdef PHI2_LOSS_FAST_EN
      run_q         <= '0;
      loss_q        <= 1'b0;
`endif
    end else begin
      count_valid_q <= 1'b0;
      mode_change_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          win_q <= '0;
          cnt_q <= '0;
          if (bus.enable) begin
            state_q <= ST_MEASURE;
            win_q   <= WIN_W'(WINDOW_CYC - 1);
`ifdef PHI2_LOSS_FAST_EN
            run_q   <= RUN_W'(LOSS_CYC);
`endif
          end
        end

        ST_MEASURE: begin
          if (!bus.enable) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            cnt_q    <= '0;
            streak_q <= '0;
          end
`ifdef PHI2_LOSS_FAST_EN
          else if (loss_hit) begin
            state_q <= ST_EVAL;
            loss_q  <= 1'b1;
            win_q   <= '0;
            cnt_q   <= '0;
          end
`endif
          else if (win_q == '0) begin
            state_q       <= ST_EVAL;
            edge_count_q  <= cnt_d;
            count_valid_q <= 1'b1;
            cnt_q         <= '0;
          end else begin
            win_q <= win_q - WIN_W'(1);
            cnt_q <= cnt_d;
`ifdef PHI2_LOSS_FAST_EN
            run_q <= bus.test_rise ? RUN_W'(LOSS_CYC) : run_q - RUN_W'(1);
`endif
          end
        end

        ST_EVAL: begin
`ifdef PHI2_LOSS_FAST_EN
          if (loss_q) begin
            loss_q   <= 1'b0;
            cand_q   <= MODE_NONE;
            streak_q <= STK_W'(CONFIRM);
            if (mode_q != MODE_NONE) begin
              mode_q        <= MODE_NONE;
              mode_locked_q <= 1'b0;
              mode_change_q <= 1'b1;
            end
          end else
`endif
          begin
            cand_q   <= cand_d;
            streak_q <= streak_d;
            if (commit_d) begin
              mode_q        <= cand_d;
              mode_locked_q <= (cand_d == MODE_C64) || (cand_d == MODE_C128);
              mode_change_q <= 1'b1;
            end
          end
          cnt_q <= '0;
          if (bus.enable) begin
            state_q <= ST_MEASURE;
            win_q   <= WIN_W'(WINDOW_CYC - 1);
`ifdef PHI2_LOSS_FAST_EN
            run_q   <= RUN_W'(LOSS_CYC);
`endif
          end else begin
            state_q <= ST_IDLE;
            win_q   <= '0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          win_q   <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.edge_count  = edge_count_q;
  assign bus.count_valid = count_valid_q;
  assign bus.mode        = mode_q;
  assign bus.mode_locked = mode_locked_q;
  assign bus.mode_change = mode_change_q;

endmodule

// File: tb/tb_phi2_mode_sequencer.sv
// Directed bench for phi2_mode_sequencer with small windows; strobe pattern is a periodic generator.
// Periods p give ceil(1000/p) strobes per window because the phase restarts at every window.
module tb_phi2_mode_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  phi2_mode_sequencer_if #(.COUNT_W(16)) bus ();

  phi2_mode_sequencer #(
    .WINDOW_CYC(1000),
    .COUNT_W   (16),
    .C64_MIN   (15),
    .C64_MAX   (25),
    .C128_MIN  (35),
    .C128_MAX  (45),
    .CONFIRM   (3),
    .LOSS_CYC  (200)
  ) dut (
    .clk_ref(clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #10 clk = ~clk;

  typedef struct {
    int period;
    int exp_cnt;
    int exp_mode;
    int exp_chg;
  } vec_t;

  vec_t tbl[20];

  int checks = 0;
  int errors = 0;
  int per = 0;
  int ph = 0;
  int cyc = 0;
  int last_strobe = 0;
  int chg_cnt = 0;

  initial begin
    bus.test_rise = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (per != 0 && (ph % per) == 0) begin
        bus.test_rise = 1'b1;
        last_strobe = cyc;
      end else begin
        bus.test_rise = 1'b0;
      end
      ph++;
    end
  end

  always @(negedge clk) if (bus.mode_change) chg_cnt++;

  initial begin
    #(80000 * 20);
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits for count_valid, checks count, arms next period, then checks mode one cycle later.
  task automatic run_win(input int exp_cnt, input int exp_mode, input int exp_chg,
                         input int next_per, input string tag, output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int n = 1; n <= 1200; n++) begin
      @(negedge clk);
      if (bus.count_valid) begin
        seen = 1'b1;
        lat = n;
        break;
      end
    end
    chk($sformatf("%s count_valid seen", tag), int'(seen), 1);
    chk($sformatf("%s edge_count", tag), int'(bus.edge_count), exp_cnt);
    per = next_per;
    ph = 0;
    @(negedge clk);
    chk($sformatf("%s mode", tag), int'(bus.mode), exp_mode);
    chk($sformatf("%s mode_locked", tag), int'(bus.mode_locked),
        (exp_mode == 1 || exp_mode == 2) ? 1 : 0);
    chk($sformatf("%s mode_change", tag), int'(bus.mode_change), exp_chg);
    chk($sformatf("%s count_valid width", tag), int'(bus.count_valid), 0);
  endtask

  initial begin
    int lat;
    int cv_seen;
    int diff;
    bit got;

    tbl[0]  = '{50, 20, 0, 0};
    tbl[1]  = '{50, 20, 0, 0};
    tbl[2]  = '{50, 20, 1, 1};
    tbl[3]  = '{25, 40, 1, 0};
    tbl[4]  = '{25, 40, 1, 0};
    tbl[5]  = '{50, 20, 1, 0};
    tbl[6]  = '{25, 40, 1, 0};
    tbl[7]  = '{25, 40, 1, 0};
    tbl[8]  = '{25, 40, 2, 1};
    tbl[9]  = '{33, 31, 2, 0};
    tbl[10] = '{33, 31, 2, 0};
    tbl[11] = '{33, 31, 3, 1};
    tbl[12] = '{40, 25, 3, 0};
    tbl[13] = '{67, 15, 3, 0};
    tbl[14] = '{72, 14, 3, 0};
    tbl[15] = '{39, 26, 3, 0};
    tbl[16] = '{23, 44, 3, 0};
    tbl[17] = '{28, 36, 3, 0};
    tbl[18] = '{23, 44, 2, 1};
    tbl[19] = '{25, 40, 2, 0};

    bus.enable = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset edge_count", int'(bus.edge_count), 0);
    chk("reset count_valid", int'(bus.count_valid), 0);
    chk("reset mode", int'(bus.mode), 0);
    chk("reset mode_locked", int'(bus.mode_locked), 0);
    chk("reset mode_change", int'(bus.mode_change), 0);

    rst = 1'b0;
    per = tbl[0].period;
    ph = 0;
    for (int i = 0; i < 20; i++) begin
      run_win(tbl[i].exp_cnt, tbl[i].exp_mode, tbl[i].exp_chg,
              (i < 19) ? tbl[i + 1].period : 25, $sformatf("vec%0d", i), lat);
      if (i == 0) chk("first count_valid latency", lat, 1001);
    end

    // Abort a window with enable low: no result, mode held
    repeat (499) @(negedge clk);
    bus.enable = 1'b0;
    cv_seen = 0;
    repeat (1200) begin
      @(negedge clk);
      if (bus.count_valid) cv_seen++;
    end
    chk("abort count_valid pulses", cv_seen, 0);
    chk("abort mode retained", int'(bus.mode), 2);
    chk("abort mode_locked", int'(bus.mode_locked), 1);

    bus.enable = 1'b1;
    per = 25;
    ph = 0;
    run_win(40, 2, 0, 25, "reenable", lat);
    chk("reenable latency", lat, 1001);

    // Reset mid-window
    repeat (500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst mode", int'(bus.mode), 0);
    chk("midrst mode_locked", int'(bus.mode_locked), 0);
    chk("midrst edge_count", int'(bus.edge_count), 0);
    @(negedge clk);
    rst = 1'b0;
    per = 50;
    ph = 0;

    run_win(20, 0, 0, 50, "relock0", lat);
    chk("post reset latency", lat, 1001);
    run_win(20, 0, 0, 50, "relock1", lat);
`ifdef PHI2_LOSS_FAST_EN
    run_win(20, 1, 1, 50, "relock2", lat);
    repeat (300) @(negedge clk);
    per = 0;
    got = 1'b0;
    diff = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (bus.mode_change) begin
        got = 1'b1;
        diff = cyc - last_strobe;
        break;
      end
    end
    chk("loss mode_change seen", int'(got), 1);
    chk("loss mode", int'(bus.mode), 0);
    chk("loss mode_locked", int'(bus.mode_locked), 0);
    chk("loss latency within 200..202", (diff >= 200 && diff <= 202) ? 1 : 0, 1);
`else
    run_win(20, 1, 1, 0, "relock2", lat);
    run_win(0, 1, 0, 0, "zero0", lat);
    run_win(0, 1, 0, 0, "zero1", lat);
    run_win(0, 0, 1, 0, "zero2", lat);
    got = 1'b1;
    diff = 0;
`endif

    @(negedge clk);
    #1;
    chk("total mode_change pulses", chg_cnt, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
